// File: rtl/fighter_pkg.sv
// Shared fighter definitions: action encoding, movement directions and key bit order.
// Used by the action controller as well as sprite and collision logic.
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WALK     = 3'd1,
    CROUCH   = 3'd2,
    JUMP     = 3'd3,
    ATK1     = 3'd4,
    ATK2     = 3'd5,
    COOLDOWN = 3'd6,
    HURT     = 3'd7
  } action_t;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  // Bit positions inside the packed key vector
  localparam int NUM_KEYS = 6;
  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_ATK1   = 4;
  localparam int K_ATK2   = 5;

  function automatic logic [1:0] dir_of(input logic left, input logic right);
    if (left && !right) return DIR_LEFT;
    if (right && !left) return DIR_RIGHT;
    return DIR_NONE;
  endfunction

  function automatic logic is_busy(input action_t a);
    return (a == JUMP) || (a == ATK1) || (a == ATK2) || (a == COOLDOWN) || (a == HURT);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Captures the key-held flags on every frame tick; a press edge is a key held now
// that was not held at the previous tick.
module key_edge_detect
  import fighter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic [NUM_KEYS-1:0] keys_i,
  output logic [NUM_KEYS-1:0] held_o,
  output logic [NUM_KEYS-1:0] press_o
);

  logic [NUM_KEYS-1:0] prev_d, prev_q;

  always_comb begin
    prev_d = prev_q;
    if (frame_tick) prev_d = keys_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= prev_d;
  end

  assign held_o  = keys_i;
  assign press_o = keys_i & ~prev_q;

endmodule

// File: rtl/fighter_action_ctrl.sv
// Frame-paced per-player action state machine: turns key flags and hit events
// into the current action, movement direction, facing and animation index.
module fighter_action_ctrl
  import fighter_pkg::*;
#(
  parameter int JUMP_FRAMES     = 16,
  parameter int ATK1_FRAMES     = 8,
  parameter int ATK2_FRAMES     = 12,
  parameter int COOLDOWN_FRAMES = 4,
  parameter int HURT_FRAMES     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       up_on,
  input  logic       down_on,
  input  logic       left_on,
  input  logic       right_on,
  input  logic       atk1_on,
  input  logic       atk2_on,
  input  logic       hit_stun,
  output action_t    action,
  output logic [1:0] move_dir,
  output logic       facing,
  output logic [3:0] anim_idx,
  output logic       attack_hit,
  output logic       busy
);

  localparam logic [4:0] JUMP_LAST = 5'(JUMP_FRAMES - 1);
  localparam logic [4:0] ATK1_LAST = 5'(ATK1_FRAMES - 1);
  localparam logic [4:0] ATK2_LAST = 5'(ATK2_FRAMES - 1);
  localparam logic [4:0] CD_LAST   = 5'(COOLDOWN_FRAMES - 1);
  localparam logic [4:0] HURT_LAST = 5'(HURT_FRAMES - 1);
  localparam logic [4:0] ATK1_MID  = 5'(ATK1_FRAMES / 2);
  localparam logic [4:0] ATK2_MID  = 5'(ATK2_FRAMES / 2);
  localparam logic [4:0] CNT_MAX   = 5'd31;

  logic [NUM_KEYS-1:0] keys, held, press;
  logic                unused_keys;
  action_t             state_d, state_q;
  logic [4:0]          cnt_d, cnt_q, cnt_inc;
  logic                hurt_pend_d, hurt_pend_q;
  logic [1:0]          walk_dir, move_dir_d, move_dir_q;
  logic                facing_d, facing_q;
  logic [3:0]          anim_idx_d, anim_idx_q;
  logic                attack_hit_d, attack_hit_q;
  logic                busy_d, busy_q;

  assign keys = {atk2_on, atk1_on, right_on, left_on, down_on, up_on};

  key_edge_detect u_keys (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .keys_i     (keys),
    .held_o     (held),
    .press_o    (press)
  );

  // Only edges of attack/jump and levels of down/left/right drive decisions
  assign unused_keys = ^{held[K_UP], held[K_ATK1], held[K_ATK2],
                         press[K_DOWN], press[K_LEFT], press[K_RIGHT]};

  assign walk_dir = dir_of(held[K_LEFT], held[K_RIGHT]);
  // Free states can linger indefinitely, so their frame count saturates
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hurt_pend_d  = hurt_pend_q | hit_stun;
    move_dir_d   = move_dir_q;
    facing_d     = facing_q;
    attack_hit_d = 1'b0;
    if (frame_tick) begin
      hurt_pend_d = hit_stun;
      if (!enable) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else if (hurt_pend_q) begin
        state_d = HURT;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE, WALK, CROUCH: begin
            if (press[K_ATK1])             state_d = ATK1;
            else if (press[K_ATK2])        state_d = ATK2;
            else if (press[K_UP])          state_d = JUMP;
            else if (held[K_DOWN])         state_d = CROUCH;
            else if (walk_dir != DIR_NONE) state_d = WALK;
            else                           state_d = IDLE;
            cnt_d = (state_d == state_q) ? cnt_inc : 5'd0;
          end
          JUMP: begin
            if (cnt_q == JUMP_LAST) begin state_d = IDLE; cnt_d = '0; end
            else cnt_d = cnt_inc;
          end
          ATK1: begin
            if (cnt_q == ATK1_LAST) begin state_d = COOLDOWN; cnt_d = '0; end
            else begin
              cnt_d        = cnt_inc;
              attack_hit_d = (cnt_inc == ATK1_MID);
            end
          end
          ATK2: begin
            if (cnt_q == ATK2_LAST) begin state_d = COOLDOWN; cnt_d = '0; end
            else begin
              cnt_d        = cnt_inc;
              attack_hit_d = (cnt_inc == ATK2_MID);
            end
          end
          COOLDOWN: begin
            if (cnt_q == CD_LAST) begin state_d = IDLE; cnt_d = '0; end
            else cnt_d = cnt_inc;
          end
          HURT: begin
            if (cnt_q == HURT_LAST) begin state_d = IDLE; cnt_d = '0; end
            else cnt_d = cnt_inc;
          end
          default: begin state_d = IDLE; cnt_d = '0; end
        endcase
      end
      move_dir_d = ((state_d == WALK) || (state_d == JUMP)) ? walk_dir : DIR_NONE;
      if (move_dir_d != DIR_NONE) facing_d = (move_dir_d == DIR_LEFT);
    end
    busy_d     = is_busy(state_d);
    anim_idx_d = (cnt_d > 5'd15) ? 4'd15 : cnt_d[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hurt_pend_q  <= 1'b0;
      move_dir_q   <= DIR_NONE;
      facing_q     <= 1'b0;
      anim_idx_q   <= '0;
      attack_hit_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hurt_pend_q  <= hurt_pend_d;
      move_dir_q   <= move_dir_d;
      facing_q     <= facing_d;
      anim_idx_q   <= anim_idx_d;
      attack_hit_q <= attack_hit_d;
      busy_q       <= busy_d;
    end
  end

  assign action     = state_q;
  assign move_dir   = move_dir_q;
  assign facing     = facing_q;
  assign anim_idx   = anim_idx_q;
  assign attack_hit = attack_hit_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Scenario bench for fighter_action_ctrl: expected output words are queued as each
// frame tick is driven and popped for comparison once the tick has been registered.
module tb_fighter_action_ctrl;
  import fighter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic       up_on = 1'b0, down_on = 1'b0, left_on = 1'b0, right_on = 1'b0;
  logic       atk1_on = 1'b0, atk2_on = 1'b0;
  logic       hit_stun = 1'b0;
  action_t    action;
  logic [1:0] move_dir;
  logic       facing;
  logic [3:0] anim_idx;
  logic       attack_hit;
  logic       busy;

  logic [11:0] exp_q[$];
  int total  = 0;
  int passed = 0;

  fighter_action_ctrl #(
    .JUMP_FRAMES(16), .ATK1_FRAMES(8), .ATK2_FRAMES(12),
    .COOLDOWN_FRAMES(4), .HURT_FRAMES(10)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .up_on(up_on), .down_on(down_on), .left_on(left_on), .right_on(right_on),
    .atk1_on(atk1_on), .atk2_on(atk2_on), .hit_stun(hit_stun),
    .action(action), .move_dir(move_dir), .facing(facing), .anim_idx(anim_idx),
    .attack_hit(attack_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected word layout: action, move_dir, facing, anim_idx, attack_hit, busy
  function automatic logic [11:0] ex(input logic [2:0] a, input logic [1:0] d, input logic f,
                                     input int anim, input logic hit, input logic b);
    logic [3:0] an;
    an = 4'(anim);
    return {a, d, f, an, hit, b};
  endfunction

  function automatic logic [11:0] obs();
    return {action, move_dir, facing, anim_idx, attack_hit, busy};
  endfunction

  task automatic tick();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    {up_on, down_on, left_on, right_on, atk1_on, atk2_on, hit_stun} = '0;
    enable = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] want;
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0))
      $display("FAIL reset_init got=%h want=%h", obs(), ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    else passed++;
    rst = 1'b0;
    atk1_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ex(ATK1, DIR_NONE, 1'b0, k, 1'b0, 1'b1));
      tick();
      atk1_on = 1'b0;
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL reset_atk1 k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
    #2 rst = 1'b1;
    #1 total++;
    if (obs() !== ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0))
      $display("FAIL reset_async got=%h want=%h", obs(), ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    else passed++;
    @(negedge clk); rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, k, 1'b0, 1'b0));
      tick();
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL reset_after k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
  endtask

  task automatic test_attack1();
    logic [11:0] want;
    do_reset();
    atk1_on = 1'b1;
    exp_q.push_back(ex(ATK1, DIR_NONE, 1'b0, 0, 1'b0, 1'b1));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL atk1_entry got=%h want=%h", obs(), want);
    else passed++;
    for (int k = 1; k <= 12; k++) begin
      atk1_on = 1'b0;
      atk2_on = (k == 2);
      if (k <= 7)       exp_q.push_back(ex(ATK1, DIR_NONE, 1'b0, k, k == 4, 1'b1));
      else if (k <= 11) exp_q.push_back(ex(COOLDOWN, DIR_NONE, 1'b0, k - 8, 1'b0, 1'b1));
      else              exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
      tick();
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL atk1_seq k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
      if (k == 4) begin
        @(negedge clk);
        total++;
        if (attack_hit !== 1'b0) $display("FAIL atk1_pulse_width got=%b want=0", attack_hit);
        else passed++;
      end
    end
  endtask

  task automatic test_walk();
    logic [11:0] want;
    do_reset();
    left_on = 1'b1; right_on = 1'b1;
    exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, 1, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL walk_both got=%h want=%h", obs(), want); else passed++;
    right_on = 1'b0;
    exp_q.push_back(ex(WALK, DIR_LEFT, 1'b1, 0, 1'b0, 1'b0));
    exp_q.push_back(ex(WALK, DIR_LEFT, 1'b1, 1, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      tick();
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL walk_left k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
    left_on = 1'b0; right_on = 1'b1;
    exp_q.push_back(ex(WALK, DIR_RIGHT, 1'b0, 2, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL walk_right got=%h want=%h", obs(), want); else passed++;
    right_on = 1'b0;
    exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL walk_stop got=%h want=%h", obs(), want); else passed++;
    down_on = 1'b1;
    exp_q.push_back(ex(CROUCH, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL crouch got=%h want=%h", obs(), want); else passed++;
    down_on = 1'b0; left_on = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs() !== ex(CROUCH, DIR_NONE, 1'b0, 0, 1'b0, 1'b0))
      $display("FAIL no_tick_hold got=%h want=%h", obs(), ex(CROUCH, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    else passed++;
    exp_q.push_back(ex(WALK, DIR_LEFT, 1'b1, 0, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL crouch_to_walk got=%h want=%h", obs(), want); else passed++;
  endtask

  task automatic test_jump();
    logic [11:0] want;
    do_reset();
    up_on = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      left_on = (k >= 3) && (k <= 5);
      if (k <= 16)
        exp_q.push_back(ex(JUMP, left_on ? DIR_LEFT : DIR_NONE, k >= 3, k - 1, 1'b0, 1'b1));
      else
        exp_q.push_back(ex(IDLE, DIR_NONE, 1'b1, (k - 17 > 15) ? 15 : k - 17, 1'b0, 1'b0));
      tick();
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL jump k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
    up_on = 1'b0;
  endtask

  task automatic test_hurt();
    logic [11:0] want;
    do_reset();
    atk2_on = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ex(ATK2, DIR_NONE, 1'b0, k, 1'b0, 1'b1));
      tick();
      atk2_on = 1'b0;
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL hurt_atk2 k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
    hit_stun = 1'b1; @(negedge clk); hit_stun = 1'b0;
    @(negedge clk);
    hit_stun = 1'b1; @(negedge clk); hit_stun = 1'b0;
    @(negedge clk);
    total++;
    if (obs() !== ex(ATK2, DIR_NONE, 1'b0, 2, 1'b0, 1'b1))
      $display("FAIL hurt_between got=%h want=%h", obs(), ex(ATK2, DIR_NONE, 1'b0, 2, 1'b0, 1'b1));
    else passed++;
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) exp_q.push_back(ex(HURT, DIR_NONE, 1'b0, k, 1'b0, 1'b1));
      else        exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
      tick();
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL hurt_seq k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
  endtask

  task automatic test_enable();
    logic [11:0] want;
    do_reset();
    enable = 1'b0; atk1_on = 1'b1;
    exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL en_low0 got=%h want=%h", obs(), want); else passed++;
    hit_stun = 1'b1; @(negedge clk); hit_stun = 1'b0;
    exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, 0, 1'b0, 1'b0));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL en_low1 got=%h want=%h", obs(), want); else passed++;
    enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      atk1_on = (k < 3);
      exp_q.push_back(ex(IDLE, DIR_NONE, 1'b0, k, 1'b0, 1'b0));
      tick();
      want = exp_q.pop_front(); total++;
      if (obs() !== want) $display("FAIL en_rise k=%0d got=%h want=%h", k, obs(), want);
      else passed++;
    end
    atk1_on = 1'b1;
    exp_q.push_back(ex(ATK1, DIR_NONE, 1'b0, 0, 1'b0, 1'b1));
    tick();
    want = exp_q.pop_front(); total++;
    if (obs() !== want) $display("FAIL en_repress got=%h want=%h", obs(), want); else passed++;
    atk1_on = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_attack1();
    test_walk();
    test_jump();
    test_hurt();
    test_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fighter_action_ctrl.md
# fighter_action_ctrl

Per-player action controller sitting directly downstream of the keyboard keycode decoder. It consumes the per-key "held" flags for one fighter, detects per-frame press edges, and runs a frame-paced action state machine (idle/walk/crouch/jump/attack/hurt) whose outputs drive sprite selection, position update and hit detection. One instance is built per player, each with its own key mapping at the top level.

## Interface
- JUMP_FRAMES, 16, frames spent in JUMP (legal 1..31)
- ATK1_FRAMES, 8, frames spent in ATK1 (legal 2..31)
- ATK2_FRAMES, 12, frames spent in ATK2 (legal 2..31)
- COOLDOWN_FRAMES, 4, frames in COOLDOWN after any attack (legal 1..31)
- HURT_FRAMES, 10, frames spent in HURT (legal 1..31)
- Clk  in  1  system clock; the block's only clock
- Reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame; all state advances on it
- enable  in  1  game running; low forces IDLE
- up_on, down_on, left_on, right_on, atk1_on, atk2_on  in  1 each  key-held flags from the decoder
- hit_stun  in  1  one-cycle pulse from collision logic: this fighter was hit
- action  out  3  current action_t
- move_dir  out  2  00 none, 01 left, 10 right (11 never driven)
- facing  out  1  0 right, 1 left
- anim_idx  out  4  frames elapsed in current action, saturating at 15
- attack_hit  out  1  one-cycle pulse: attack active frame
- busy  out  1  high in JUMP, ATK1, ATK2, COOLDOWN, HURT

## Operation
- States: IDLE, WALK, CROUCH, JUMP, ATK1, ATK2, COOLDOWN, HURT.
- Key flags captured into cur registers each frame_tick; prev <= cur on the same tick. Press edge = key & ~prev. prev updates even when enable is low, so keys held across enable rise produce no edge.
- Free states (IDLE/WALK/CROUCH), evaluated at tick, priority: atk1 edge -> ATK1; atk2 edge -> ATK2; up edge -> JUMP; down held -> CROUCH; exactly one of left/right held -> WALK; else IDLE.
- WALK/JUMP: move_dir follows held left/right (both or neither -> 00); facing updates to match a nonzero move_dir. move_dir 00 in all other states.
- Timed states use 5-bit frame counter cnt, cleared on entry, incremented each tick. JUMP/HURT exit to IDLE when cnt reaches N-1. ATK1/ATK2 exit to COOLDOWN at N-1; COOLDOWN exits to IDLE at N-1. Edges during timed states are ignored (not queued).
- attack_hit pulses when in ATK1/ATK2 and the tick advances cnt to N/2 (integer division).
- hit_stun pulse at any cycle sets hurt_pend; at next tick hurt_pend forces HURT from any state (restarts cnt if already HURT) and clears. Takes priority over all key decisions.
- enable low: at each tick state <= IDLE, cnt <= 0, hurt_pend cleared; attack_hit never asserted.
- anim_idx = min(cnt, 15); for free states cnt counts frames held in that state and resets on state change.

## Timing
- All outputs registered. Reset values: action IDLE, move_dir 00, facing 0, anim_idx 0, attack_hit 0, busy 0; prev/cur/cnt/hurt_pend 0.
- Latency: key change sampled at tick T; action/move_dir/anim_idx reflect it from cycle T+1. attack_hit high exactly cycle T+1 for the qualifying tick.
- No state change on cycles without frame_tick; hit_stun between ticks is held, never lost; multiple hit_stun pulses before one tick collapse to one.
- Reset mid-action returns to IDLE immediately, no pending pulses survive.

## Structure
- fighter_pkg: action_t enum (3-bit, IDLE=0..HURT=7), DIR_NONE/LEFT/RIGHT constants; shared with sprite and collision logic.
- Sub-module key_edge_detect: registers the 6 flags on frame_tick and outputs held and press-edge vectors.

## Test plan
- Reset asserted mid-ATK1 -> all outputs at reset values next cycle; after release action stays IDLE with no keys.
- atk1_on rises, tick -> ATK1, attack_hit single pulse on tick 4 of attack (ATK1_FRAMES=8), COOLDOWN after 8 ticks, IDLE after 4 more.
- left and right both held in IDLE -> IDLE, move_dir 00; release right -> WALK, move_dir 01, facing 1.
- up held continuously across 40 ticks -> exactly one JUMP (16 ticks) then IDLE, no re-jump.
- hit_stun pulse during ATK2 between ticks -> HURT at next tick, no attack_hit, IDLE after 10 ticks.
- enable low while atk1_on pressed, then enable high with key still held -> stays IDLE, no ATK1.
